debug_ram_access_ctrl: RTL and testbench
========================================

DEBUG_RAM_ACCESS_CTRL -- requirements
Module: debug_ram_access_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX, default 8, giving the word-address width of the debug data RAM.
REQ-002 The block SHALL have parameter WIDTH, default 64, giving the word width; it SHALL equal 8 bytes, so the byte index is 3 bits.
REQ-003 Port clk  input  1  clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port dbgReq_i  input  1  debug host request; sampled only in IDLE.
REQ-006 Port dbgWrite_i  input  1  1 = word write, 0 = word read.
REQ-007 Port dbgAddr_i  input  INDEX  target word address.
REQ-008 Port dbgWrData_i  input  WIDTH  write word.
REQ-009 Port dbgAck_o  output  1  one-cycle completion pulse.
REQ-010 Port dbgRdData_o  output  WIDTH  assembled read word.
REQ-011 Port dbgBusy_o  output  1  high whenever state is not IDLE.
REQ-012 Port coreWe_i  input  1  core write to the RAM this cycle; it has priority over the scratch port.
REQ-013 Port scratchAddr_o  output  INDEX+3  byte address, formed as {byteIdx[2:0], wordAddr[INDEX-1:0]}.
REQ-014 Port scratchWrData_o  output  8  byte write data.
REQ-015 Port scratchWrEn_o  output  1  byte write strobe.
REQ-016 Port scratchRdData_i  input  8  byte read data, combinational from scratchAddr_o in the same cycle.
REQ-017 Port verifyErr_o  output  1  sticky readback mismatch flag; present only under DEBUG_RAM_CTRL_VERIFY_EN.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, VERIFY and DONE.
REQ-019 In IDLE, dbgReq_i=1 SHALL latch address, data and op, clear byteIdx to 0, and enter WRITE if dbgWrite_i=1, else READ.
REQ-020 dbgReq_i SHALL be ignored in every state other than IDLE; no queuing SHALL occur.
REQ-021 In WRITE, scratchWrEn_o SHALL equal !coreWe_i, with scratchWrData_o = latched data bits [8*byteIdx+7 -: 8].
REQ-022 byteIdx SHALL advance only on a cycle where scratchWrEn_o=1; a cycle with coreWe_i=1 SHALL stall without losing the pending byte.
REQ-023 After byte 7 is written, WRITE SHALL go to VERIFY when the macro is defined, else to DONE.
REQ-024 In READ, each cycle SHALL capture scratchRdData_i into dbgRdData_o byte byteIdx and advance byteIdx; reads SHALL NOT stall on coreWe_i.
REQ-025 After byte 7 is read, READ SHALL go to DONE.
REQ-026 In DONE, dbgAck_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 dbgRdData_o SHALL hold its value from DONE until the next read begins capturing.
REQ-028 Uncontended latency, request accepted in cycle T, SHALL be: read ack at T+9; write ack at T+9 without the macro, T+17 with it.
REQ-029 byteIdx SHALL be 3 bits, and its wrap from 7 to 0 SHALL coincide with the state exit.
REQ-030 scratchWrEn_o SHALL be 0 in every state except WRITE.

Reset
REQ-031 On reset the FSM SHALL enter IDLE, including mid-operation, with no ack issued.
REQ-032 On reset, byteIdx, dbgAck_o, dbgBusy_o, scratchWrEn_o, scratchAddr_o, scratchWrData_o, dbgRdData_o and verifyErr_o SHALL be 0.

Configuration
REQ-033 With DEBUG_RAM_CTRL_VERIFY_EN defined, a completed write SHALL pass through VERIFY.
REQ-034 VERIFY SHALL read bytes 0..7 back in 8 cycles and compare each against the latched data.
REQ-035 Any VERIFY mismatch SHALL set verifyErr_o, which stays set until reset.
REQ-036 Without the macro, the VERIFY state and the verifyErr_o port SHALL be absent, and WRITE SHALL go directly to DONE.

Verification
REQ-037 Write 0x0123456789ABCDEF to addr 0x05, coreWe_i=0 -> scratchAddr_o 0x005,0x105..0x705 with data 0xEF,0xCD..0x01; ack at T+9 (T+17 with macro).
REQ-038 Read addr 0x05 after REQ-037 -> dbgRdData_o=0x0123456789ABCDEF and ack at T+9.
REQ-039 Write with coreWe_i=1 for 3 cycles during byte 2 -> scratchWrEn_o=0 for those 3 cycles; byte 2 is written afterwards; ack delayed by 3 cycles.
REQ-040 Assert dbgReq_i while dbgBusy_o=1 -> the request is ignored and exactly one ack is produced.
REQ-041 Assert reset during byte 4 of a write -> next cycle IDLE with all outputs 0 and no ack; a new request then starts again at byte 0.
REQ-042 With the macro, a RAM model forcing byte 3 to 0x00 -> verifyErr_o=1 after ack, and it stays 1 until reset.

Source files
------------

// File: rtl/debug_ram_access_ctrl_if.sv
// rtl/debug_ram_access_ctrl_if.sv - debug host and byte-wide scratch RAM port bundle for debug_ram_access_ctrl
interface debug_ram_access_ctrl_if #(
    parameter int INDEX = 8,
    parameter int WIDTH = 64
);
    logic             dbgReq_i;
    logic             dbgWrite_i;
    logic [INDEX-1:0] dbgAddr_i;
    logic [WIDTH-1:0] dbgWrData_i;
    logic             dbgAck_o;
    logic [WIDTH-1:0] dbgRdData_o;
    logic             dbgBusy_o;
    logic             coreWe_i;
    logic [INDEX+2:0] scratchAddr_o;
    logic [7:0]       scratchWrData_o;
    logic             scratchWrEn_o;
    logic [7:0]       scratchRdData_i;

    modport slave (
        input  dbgReq_i, dbgWrite_i, dbgAddr_i, dbgWrData_i, coreWe_i, scratchRdData_i,
        output dbgAck_o, dbgRdData_o, dbgBusy_o, scratchAddr_o, scratchWrData_o, scratchWrEn_o
    );

    modport master (
        output dbgReq_i, dbgWrite_i, dbgAddr_i, dbgWrData_i, coreWe_i, scratchRdData_i,
        input  dbgAck_o, dbgRdData_o, dbgBusy_o, scratchAddr_o, scratchWrData_o, scratchWrEn_o
    );
endinterface

// File: rtl/debug_ram_access_ctrl.sv
// rtl/debug_ram_access_ctrl.sv - serialises 64-bit debug word accesses onto a byte-wide scratch RAM port
// Optional write readback check enabled by defining DEBUG_RAM_CTRL_VERIFY_EN.
module debug_ram_access_ctrl #(
    parameter int INDEX = 8,
    parameter int WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    debug_ram_access_ctrl_if.slave        bus
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
    ,
    output logic                          verifyErr_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [INDEX-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [5:0]       bit_base;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             ack;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
    logic             verify_err_q, verify_err_d;
`endif

    assign bit_base = {byte_idx_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        ack        = 1'b0;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.dbgReq_i) begin
                    addr_d     = bus.dbgAddr_i;
                    data_d     = bus.dbgWrData_i;
                    byte_idx_d = 3'd0;
                    state_d    = bus.dbgWrite_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // The core owns the RAM port this cycle; hold the pending byte.
                wr_en   = !bus.coreWe_i;
                wr_data = data_q[bit_base +: 8];
                if (wr_en) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'd7) begin
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_READ: begin
                rd_data_d[bit_base +: 8] = bus.scratchRdData_i;
                byte_idx_d = byte_idx_q + 3'd1;
                if (byte_idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (bus.scratchRdData_i != data_q[bit_base +: 8]) begin
                    verify_err_d = 1'b1;
                end
                byte_idx_d = byte_idx_q + 3'd1;
                if (byte_idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 3'd0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign bus.dbgAck_o        = ack;
    assign bus.dbgBusy_o       = (state_q != ST_IDLE);
    assign bus.dbgRdData_o     = rd_data_q;
    assign bus.scratchAddr_o   = {byte_idx_q, addr_q};
    assign bus.scratchWrData_o = wr_data;
    assign bus.scratchWrEn_o   = wr_en;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
    assign verifyErr_o         = verify_err_q;
`endif

endmodule

// File: tb/tb_debug_ram_access_ctrl.sv
// tb/tb_debug_ram_access_ctrl.sv - self-checking bench for debug_ram_access_ctrl against a word-level RAM model
module tb_debug_ram_access_ctrl;
    localparam int INDEX = 8;
    localparam int WIDTH = 64;
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
    localparam int VERIFY_CYC = 8;
`else
    localparam int VERIFY_CYC = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    debug_ram_access_ctrl_if #(.INDEX(INDEX), .WIDTH(WIDTH)) bus ();
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
    logic verifyErr_o;
`endif

    debug_ram_access_ctrl #(.INDEX(INDEX), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
        ,
        .verifyErr_o (verifyErr_o)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  mem     [0:2047];
    logic [63:0] ref_mem [0:255];
    logic [7:0]  pool    [0:7];
    bit          corrupt_b3 = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always_comb bus.scratchRdData_i = (corrupt_b3 && bus.scratchAddr_o[10:8] == 3'd3) ? 8'h00 : mem[bus.scratchAddr_o];
    always @(posedge clk) if (bus.scratchWrEn_o) mem[bus.scratchAddr_o] <= bus.scratchWrData_o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"},   bus.dbgAck_o, 0);
        check({tag, "_busy"},  bus.dbgBusy_o, 0);
        check({tag, "_wren"},  bus.scratchWrEn_o, 0);
        check({tag, "_addr"},  bus.scratchAddr_o, 0);
        check({tag, "_wdata"}, bus.scratchWrData_o, 0);
        check({tag, "_rdata"}, bus.dbgRdData_o, 0);
`ifdef DEBUG_RAM_CTRL_VERIFY_EN
        check({tag, "_verr"},  verifyErr_o, 0);
`endif
    endtask

    // mode 0: no core traffic, 1: core stalls 3 cycles at byte 2, 2: random core traffic, 3: requests while busy
    task automatic run_op(input bit wr, input logic [7:0] a, input logic [63:0] d, input int mode, output int lat);
        int cyc, stalls, nbytes, rb, extra_acks;
        bit seq_ok, done;
        @(negedge clk);
        check("idle_before_req", bus.dbgBusy_o, 0);
        bus.dbgReq_i = 1'b1; bus.dbgWrite_i = wr; bus.dbgAddr_i = a; bus.dbgWrData_i = d; bus.coreWe_i = 1'b0;
        @(negedge clk);
        bus.dbgReq_i = 1'b0; bus.dbgAddr_i = ~a; bus.dbgWrData_i = ~d;
        cyc = 1; stalls = 0; nbytes = 0; rb = 0; seq_ok = 1'b1; done = 1'b0; lat = -1;
        while (!done && cyc < 64) begin
            case (mode)
                1: bus.coreWe_i = (wr && nbytes == 2 && stalls < 3);
                2: bus.coreWe_i = ($urandom_range(0, 3) == 0);
                default: bus.coreWe_i = 1'b0;
            endcase
            if (mode == 3) begin
                bus.dbgReq_i = (cyc >= 2 && cyc <= 6);
                bus.dbgWrite_i = !wr;
            end
            #1;
            if (bus.dbgAck_o) begin
                if (bus.scratchWrEn_o !== 1'b0) seq_ok = 1'b0;
                lat = cyc;
                done = 1'b1;
            end else begin
                if (bus.dbgBusy_o !== 1'b1) seq_ok = 1'b0;
                if (wr && nbytes < 8) begin
                    if (bus.scratchWrEn_o !== !bus.coreWe_i) seq_ok = 1'b0;
                    if (bus.scratchWrEn_o) begin
                        if (bus.scratchAddr_o !== {nbytes[2:0], a} || bus.scratchWrData_o !== d[8*nbytes +: 8]) seq_ok = 1'b0;
                        nbytes++;
                    end else begin
                        stalls++;
                    end
                end else if (bus.scratchWrEn_o !== 1'b0) begin
                    seq_ok = 1'b0;
                end
                if (!wr && rb < 8) begin
                    if (bus.scratchAddr_o !== {rb[2:0], a}) seq_ok = 1'b0;
                    rb++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("ack_seen", done, 1);
        check("latency", lat, 9 + (wr ? stalls + VERIFY_CYC : 0));
        check(wr ? "write_sequence" : "read_sequence", seq_ok, 1);
        if (!wr) check("read_data", bus.dbgRdData_o, ref_mem[a]);
        @(negedge clk);
        bus.dbgReq_i = 1'b0; bus.dbgWrite_i = 1'b0; bus.coreWe_i = 1'b0;
        check("ack_one_cycle", bus.dbgAck_o, 0);
        check("busy_after_done", bus.dbgBusy_o, 0);
        if (!wr) check("read_data_hold", bus.dbgRdData_o, ref_mem[a]);
        if (mode == 3) begin
            extra_acks = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.dbgAck_o || bus.dbgBusy_o) extra_acks++;
            end
            check("ignored_req_no_activity", extra_acks, 0);
        end
        if (wr) ref_mem[a] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stray;
        logic [7:0] a;
        bus.dbgReq_i = 1'b0; bus.dbgWrite_i = 1'b0; bus.dbgAddr_i = '0; bus.dbgWrData_i = '0; bus.coreWe_i = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        pool[0] = 8'h05;
        for (int i = 1; i < 8; i++) pool[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) run_op(1'b1, pool[i], {$urandom, $urandom}, 0, lat);

        run_op(1'b1, 8'h05, 64'h0123456789ABCDEF, 0, lat);
        check("write_lat_uncontended", lat, 9 + VERIFY_CYC);
        run_op(1'b0, 8'h05, 64'h0, 0, lat);
        check("read_lat", lat, 9);
        check("read_const", bus.dbgRdData_o, 64'h0123456789ABCDEF);

        run_op(1'b1, 8'h05, 64'hFEDCBA9876543210, 1, lat);
        check("write_lat_stalled", lat, 12 + VERIFY_CYC);
        run_op(1'b0, 8'h05, 64'h0, 2, lat);

        run_op(1'b0, pool[1], 64'h0, 3, lat);
        run_op(1'b1, pool[1], 64'hA5A5_5A5A_0F0F_F0F0, 3, lat);

        a = pool[2];
        @(negedge clk);
        bus.dbgReq_i = 1'b1; bus.dbgWrite_i = 1'b1; bus.dbgAddr_i = a; bus.dbgWrData_i = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.dbgReq_i = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_at_byte4_addr", bus.scratchAddr_o, {3'd4, a});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("mid_write_reset");
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dbgAck_o || bus.dbgBusy_o) stray++;
        end
        check("reset_no_ack", stray, 0);
        run_op(1'b1, a, 64'h5555_6666_7777_8888, 0, lat);
        run_op(1'b0, a, 64'h0, 0, lat);

`ifdef DEBUG_RAM_CTRL_VERIFY_EN
        check("verify_clean", verifyErr_o, 0);
        corrupt_b3 = 1'b1;
        run_op(1'b1, pool[3], 64'h0123456789ABCDEF, 0, lat);
        corrupt_b3 = 1'b0;
        check("verify_err_set", verifyErr_o, 1);
        run_op(1'b0, pool[3], 64'h0, 2, lat);
        check("verify_err_sticky", verifyErr_o, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("verify_err_reset", verifyErr_o, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], {$urandom, $urandom}, 2, lat);
        end
        for (int i = 0; i < 8; i++) run_op(1'b0, pool[i], 64'h0, 2, lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
